// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and width helper for the TX serializer arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte-stream bus plus the TX serializer write port.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    grant;
    logic               tx_wen;
    logic [DW-1:0]      tx_din;
    logic               tx_rdy;

    modport master (
        output req_valid, req_data, req_last, tx_rdy,
        input  req_ready, grant, tx_wen, tx_din
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_rdy,
        output req_ready, grant, tx_wen, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after i_last, wrapping.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    int w_best;
    int w_dist;

    // Distance 0 is the requester right after i_last; smallest distance wins.
    always_comb begin
        w_best = N;
        w_dist = 0;
        o_idx  = '0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - 1 - int'(i_last)) % N;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IW'(i);
            end
        end
    end

    assign o_any    = |i_req;
    assign o_onehot = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one TX serializer through a one-byte holding register.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_arbiter_if.slave bus,
    output logic             o_busy
);
    localparam int IW = clog2_min1(NREQ);
    localparam int CW = clog2_min1(MAX_BURST + 1);

    arb_state_t      r_state;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_req_ready;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_last_grant;
    logic            r_hold_valid;
    logic [DW-1:0]   r_hold_data;
    logic            r_rel_pend;
    logic [CW-1:0]   r_burst_cnt;

    logic [NREQ-1:0] w_pick_onehot;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [DW-1:0]   w_req_dat;
    logic            w_req_last;
    logic            w_accept;
    logic            w_tx_done;
    logic            w_burst_hit;
    logic            w_release;
    logic            w_hold_nxt;
    logic            w_rel_nxt;

    uart_tx_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .i_req    (bus.req_valid),
        .i_last   (r_last_grant),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_req_dat   = bus.req_data[int'(r_gidx)*DW +: DW];
    assign w_req_last  = bus.req_last[r_gidx];
    assign w_accept    = |(bus.req_valid & r_req_ready);
    assign w_tx_done   = r_hold_valid & bus.tx_rdy;
    assign w_burst_hit = (MAX_BURST != 0) && ((int'(r_burst_cnt) + 1) == MAX_BURST);
    assign w_release   = w_tx_done & r_rel_pend;
    assign w_hold_nxt  = w_accept | (r_hold_valid & ~bus.tx_rdy);
    assign w_rel_nxt   = ~w_release & (r_rel_pend | (w_accept & (w_req_last | w_burst_hit)));

    assign bus.req_ready = r_req_ready;
    assign bus.grant     = r_grant;
    assign bus.tx_wen    = r_hold_valid;
    assign bus.tx_din    = r_hold_data;
    assign o_busy        = (r_state != ST_IDLE) | r_hold_valid;

    // req_ready is computed from next-state values so tx_rdy only reaches it through a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_req_ready  <= '0;
            r_gidx       <= '0;
            r_last_grant <= IW'(NREQ - 1);
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_rel_pend   <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            r_hold_valid <= w_hold_nxt;
            r_rel_pend   <= w_rel_nxt;
            if (w_accept) begin
                r_hold_data <= w_req_dat;
            end
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= '0;
                    if (w_pick_any) begin
                        r_state     <= ST_OWN;
                        r_grant     <= w_pick_onehot;
                        r_gidx      <= w_pick_idx;
                        r_req_ready <= w_pick_onehot;
                    end
                end
                ST_OWN: begin
                    if (w_accept && (MAX_BURST != 0)) begin
                        r_burst_cnt <= r_burst_cnt + CW'(1);
                    end
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= '0;
                        r_req_ready  <= '0;
                        r_last_grant <= r_gidx;
                        r_burst_cnt  <= '0;
                    end else begin
                        r_req_ready <= r_grant & {NREQ{~w_hold_nxt & ~w_rel_nxt}};
                    end
                end
            endcase
        end
    end

endmodule
